// File: rtl/hd63701_mcseq_pkg.sv
// ============================================================================
// hd63701_mcseq_pkg : shared constants and types for the microcode sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package hd63701_mcseq_pkg;

  localparam int SEQ_W = 9;

  localparam logic [SEQ_W-1:0] SEQ_RESET = 9'd256;
  localparam logic [SEQ_W-1:0] SEQ_INTR  = 9'd257;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_OP = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_WAIT = 2'd0,
    SEL_IRQ  = 2'd1,
    SEL_OP   = 2'd2
  } sel_t;

  function automatic int step_w(input int nph);
    return $clog2(nph);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hd63701_mcseq_if.sv
// ============================================================================
// hd63701_mcseq_if : sequencer <-> ROM/datapath signal bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface hd63701_mcseq_if #(
  parameter int MCW = 26,
  parameter int SW  = 4
);
  import hd63701_mcseq_pkg::*;

  logic                  clken;
  logic [7:0]            opcode;
  logic                  opcode_vld;
  logic                  irq_req;
  logic [MCW-1:0]        rom_data;
  logic [SEQ_W+SW-1:0]   rom_addr;
  logic                  rom_en;
  logic [MCW-1:0]        mcode;
  logic                  mc_valid;
  logic                  irq_ack;
  logic                  opcode_take;
  logic                  halted;
  logic                  err_ovr;

  modport master (
    input  clken, opcode, opcode_vld, irq_req, rom_data,
    output rom_addr, rom_en, mcode, mc_valid, irq_ack, opcode_take, halted, err_ovr
  );

  modport slave (
    output clken, opcode, opcode_vld, irq_req, rom_data,
    input  rom_addr, rom_en, mcode, mc_valid, irq_ack, opcode_take, halted, err_ovr
  );

endinterface

`default_nettype wire

// File: rtl/hd63701_mcseq_sel.sv
// ============================================================================
// hd63701_mcseq_sel : next-sequence priority selector (irq > opcode > wait)
// Revision 1.0
// ============================================================================
`default_nettype none

module hd63701_mcseq_sel
  import hd63701_mcseq_pkg::*;
(
  input  logic             irq_req,
  input  logic             opcode_vld,
  input  logic [7:0]       opcode,
  input  logic             op_allow,
  output sel_t             sel,
  output logic [SEQ_W-1:0] next_seq
);

  always_comb begin
    sel      = SEL_WAIT;
    next_seq = {1'b0, opcode};
    if (irq_req) begin
      sel      = SEL_IRQ;
      next_seq = SEQ_INTR;
    end else if (opcode_vld && op_allow) begin
      sel      = SEL_OP;
      next_seq = {1'b0, opcode};
    end
  end

endmodule

`default_nettype wire

// File: rtl/hd63701_mcseq.sv
// ============================================================================
// hd63701_mcseq : pipelined microcode sequencer with speculative step prefetch
// Revision 1.0
// ============================================================================
`default_nettype none

module hd63701_mcseq
  import hd63701_mcseq_pkg::*;
#(
  parameter int MCW      = 26,
  parameter int NPH      = 16,
  parameter int END_BIT  = 25,
  parameter int HALT_BIT = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hd63701_mcseq_if.master      bus
);

  localparam int            SW        = step_w(NPH);
  localparam logic [SW-1:0] STEP_LAST = SW'(NPH - 1);

  state_t             r_state;
  logic [SEQ_W-1:0]   r_seq;
  logic [SW-1:0]      r_step;
  logic [SW-1:0]      r_data_step;
  logic               r_pend;
  logic               r_kill;
  logic [MCW-1:0]     r_mcode;
  logic               r_mc_valid;
  logic               r_irq_ack;
  logic               r_opcode_take;
  logic               r_halted;
  logic               r_err_ovr;

  logic               w_live;
  logic               w_halt;
  logic               w_end;
  logic               w_ovr;
  sel_t               w_sel;
  logic [SEQ_W-1:0]   w_next_seq;

  // r_pend marks that rom_data answers an address issued while running;
  // r_kill additionally squashes the speculative step after a boundary.
  assign w_live = (r_state == ST_RUN) && r_pend && !r_kill;
  assign w_halt = w_live && bus.rom_data[HALT_BIT];
  assign w_ovr  = w_live && !bus.rom_data[END_BIT] && (r_data_step == STEP_LAST);
  assign w_end  = w_live && (bus.rom_data[END_BIT] || (r_data_step == STEP_LAST));

  hd63701_mcseq_sel u_sel (
    .irq_req    (bus.irq_req),
    .opcode_vld (bus.opcode_vld),
    .opcode     (bus.opcode),
    .op_allow   (r_state != ST_HALT),
    .sel        (w_sel),
    .next_seq   (w_next_seq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_seq         <= SEQ_RESET;
      r_step        <= '0;
      r_data_step   <= '0;
      r_pend        <= 1'b0;
      r_kill        <= 1'b0;
      r_mcode       <= '0;
      r_mc_valid    <= 1'b0;
      r_irq_ack     <= 1'b0;
      r_opcode_take <= 1'b0;
      r_halted      <= 1'b0;
      r_err_ovr     <= 1'b0;
    end else if (bus.clken) begin
      r_irq_ack     <= 1'b0;
      r_opcode_take <= 1'b0;
      r_data_step   <= r_step;
      r_pend        <= (r_state == ST_RUN);
      case (r_state)
        ST_RUN: begin
          if (r_kill || !r_pend) begin
            r_mc_valid <= 1'b0;
            r_kill     <= 1'b0;
          end else begin
            r_mcode    <= bus.rom_data;
            r_mc_valid <= 1'b1;
          end
          r_step <= r_step + 1'b1;
          if (w_halt) begin
            r_kill   <= 1'b1;
            r_step   <= r_step;
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (w_end) begin
            r_kill <= 1'b1;
            if (w_ovr) begin
              r_err_ovr <= 1'b1;
            end
            if (w_sel != SEL_WAIT) begin
              r_seq         <= w_next_seq;
              r_step        <= '0;
              r_irq_ack     <= (w_sel == SEL_IRQ);
              r_opcode_take <= (w_sel == SEL_OP);
            end else begin
              r_step  <= r_step;
              r_state <= ST_WAIT_OP;
            end
          end
        end
        ST_WAIT_OP, ST_HALT: begin
          r_mc_valid <= 1'b0;
          r_kill     <= 1'b0;
          if (w_sel != SEL_WAIT) begin
            r_seq         <= w_next_seq;
            r_step        <= '0;
            r_state       <= ST_RUN;
            r_halted      <= 1'b0;
            r_irq_ack     <= (w_sel == SEL_IRQ);
            r_opcode_take <= (w_sel == SEL_OP);
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.rom_addr    = {r_seq, r_step};
  assign bus.rom_en      = bus.clken;
  assign bus.mcode       = r_mcode;
  assign bus.mc_valid    = r_mc_valid;
  assign bus.irq_ack     = r_irq_ack;
  assign bus.opcode_take = r_opcode_take;
  assign bus.halted      = r_halted;
  assign bus.err_ovr     = r_err_ovr;

endmodule

`default_nettype wire

// File: tb/tb_hd63701_mcseq.sv
// ============================================================================
// tb_hd63701_mcseq : directed bench with a behavioural microcode ROM
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_hd63701_mcseq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  hd63701_mcseq_if #(.MCW(26), .SW(4)) bus ();

  hd63701_mcseq #(
    .MCW(26), .NPH(16), .END_BIT(25), .HALT_BIT(24)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM image: {END, HALT, 7'd0, seq, 4'd0, step}
  function automatic logic [25:0] rom_word(input logic [8:0] s, input logic [3:0] st);
    logic e;
    logic h;
    e = 1'b0;
    h = 1'b0;
    case (s)
      9'd256: e = (st == 4'd2);
      9'h086: e = (st == 4'd1);
      9'd257: e = (st == 4'd1);
      9'h010: e = 1'b0;
      9'h020: begin h = (st == 4'd1); e = (st == 4'd1); end
      9'h030: e = (st == 4'd2);
      default: e = 1'b1;
    endcase
    return {e, h, 7'd0, s, 4'd0, st};
  endfunction

  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom_word(bus.rom_addr[12:4], bus.rom_addr[3:0]);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [8:0] s, input logic [3:0] st,
                     input logic v, input logic [25:0] mc);
    check({tag, ".addr"}, 64'(bus.rom_addr), 64'({s, st}));
    check({tag, ".vld"}, 64'(bus.mc_valid), 64'(v));
    if (v) check({tag, ".mcode"}, 64'(bus.mcode), 64'(mc));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".addr"}, 64'(bus.rom_addr), 64'({9'd256, 4'd0}));
    check({tag, ".mcode"}, 64'(bus.mcode), 64'd0);
    check({tag, ".vld"}, 64'(bus.mc_valid), 64'd0);
    check({tag, ".ack"}, 64'(bus.irq_ack), 64'd0);
    check({tag, ".take"}, 64'(bus.opcode_take), 64'd0);
    check({tag, ".halted"}, 64'(bus.halted), 64'd0);
    check({tag, ".err"}, 64'(bus.err_ovr), 64'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.clken      = 1'b1;
    bus.opcode     = 8'h86;
    bus.opcode_vld = 1'b1;
    bus.irq_req    = 1'b0;
    repeat (3) tick();
    check_reset("rst");
    rst_n = 1'b1;

    // RESET sequence, then opcode 0x86 taken at its END
    tick(); cyc("e1", 9'd256, 4'd1, 1'b0, '0);
    tick(); cyc("e2", 9'd256, 4'd2, 1'b1, rom_word(9'd256, 4'd0));
    tick(); cyc("e3", 9'd256, 4'd3, 1'b1, rom_word(9'd256, 4'd1));
    tick(); cyc("e4", 9'h086, 4'd0, 1'b1, rom_word(9'd256, 4'd2));
    check("e4.take", 64'(bus.opcode_take), 64'd1);
    check("e4.ack", 64'(bus.irq_ack), 64'd0);
    tick(); cyc("e5", 9'h086, 4'd1, 1'b0, '0);
    check("e5.take", 64'(bus.opcode_take), 64'd0);
    tick(); cyc("e6", 9'h086, 4'd2, 1'b1, rom_word(9'h086, 4'd0));
    bus.irq_req = 1'b1;

    // irq and opcode both pending at END: irq wins
    tick(); cyc("e7", 9'd257, 4'd0, 1'b1, rom_word(9'h086, 4'd1));
    check("e7.ack", 64'(bus.irq_ack), 64'd1);
    check("e7.take", 64'(bus.opcode_take), 64'd0);
    bus.irq_req    = 1'b0;
    bus.opcode_vld = 1'b0;
    tick(); cyc("e8", 9'd257, 4'd1, 1'b0, '0);
    check("e8.ack", 64'(bus.irq_ack), 64'd0);
    tick(); cyc("e9", 9'd257, 4'd2, 1'b1, rom_word(9'd257, 4'd0));
    tick(); cyc("e10", 9'd257, 4'd2, 1'b1, rom_word(9'd257, 4'd1));
    repeat (2) begin
      tick(); cyc("wait", 9'd257, 4'd2, 1'b0, '0);
    end

    // Sequence 0x10 never ends: forced boundary at step 15
    bus.opcode     = 8'h10;
    bus.opcode_vld = 1'b1;
    tick(); cyc("e13", 9'h010, 4'd0, 1'b0, '0);
    check("e13.take", 64'(bus.opcode_take), 64'd1);
    bus.opcode = 8'h20;
    tick(); cyc("e14", 9'h010, 4'd1, 1'b0, '0);
    for (int k = 0; k < 15; k++) begin
      tick(); cyc("ovr_run", 9'h010, 4'(k + 2), 1'b1, rom_word(9'h010, 4'(k)));
      check("ovr_run.err", 64'(bus.err_ovr), 64'd0);
    end
    tick(); cyc("ovr_end", 9'h020, 4'd0, 1'b1, rom_word(9'h010, 4'd15));
    check("ovr_end.err", 64'(bus.err_ovr), 64'd1);
    check("ovr_end.take", 64'(bus.opcode_take), 64'd1);
    bus.opcode_vld = 1'b0;
    tick(); cyc("h0", 9'h020, 4'd1, 1'b0, '0);
    check("h0.err", 64'(bus.err_ovr), 64'd1);
    tick(); cyc("h1", 9'h020, 4'd2, 1'b1, rom_word(9'h020, 4'd0));
    check("h1.halted", 64'(bus.halted), 64'd0);

    // HALT+END word: halt wins, opcode ignored while halted
    bus.opcode     = 8'h86;
    bus.opcode_vld = 1'b1;
    tick(); cyc("halt_word", 9'h020, 4'd2, 1'b1, rom_word(9'h020, 4'd1));
    check("halt_word.halted", 64'(bus.halted), 64'd1);
    check("halt_word.take", 64'(bus.opcode_take), 64'd0);
    repeat (5) begin
      tick(); cyc("halt", 9'h020, 4'd2, 1'b0, '0);
      check("halt.halted", 64'(bus.halted), 64'd1);
      check("halt.take", 64'(bus.opcode_take), 64'd0);
    end
    bus.irq_req = 1'b1;
    tick(); cyc("unhalt", 9'd257, 4'd0, 1'b0, '0);
    check("unhalt.halted", 64'(bus.halted), 64'd0);
    check("unhalt.ack", 64'(bus.irq_ack), 64'd1);
    bus.irq_req    = 1'b0;
    bus.opcode_vld = 1'b0;
    tick(); cyc("i1", 9'd257, 4'd1, 1'b0, '0);
    tick(); cyc("i2", 9'd257, 4'd2, 1'b1, rom_word(9'd257, 4'd0));
    tick(); cyc("i3", 9'd257, 4'd2, 1'b1, rom_word(9'd257, 4'd1));
    check("i3.err", 64'(bus.err_ovr), 64'd1);

    // clken low freezes a pulse, then freezes a live word mid-sequence
    bus.opcode     = 8'h30;
    bus.opcode_vld = 1'b1;
    tick(); cyc("c0", 9'h030, 4'd0, 1'b0, '0);
    check("c0.take", 64'(bus.opcode_take), 64'd1);
    bus.opcode_vld = 1'b0;
    bus.clken      = 1'b0;
    repeat (4) begin
      tick(); cyc("frz1", 9'h030, 4'd0, 1'b0, '0);
      check("frz1.take", 64'(bus.opcode_take), 64'd1);
    end
    bus.clken = 1'b1;
    tick(); cyc("c1", 9'h030, 4'd1, 1'b0, '0);
    check("c1.take", 64'(bus.opcode_take), 64'd0);
    tick(); cyc("c2", 9'h030, 4'd2, 1'b1, rom_word(9'h030, 4'd0));
    bus.clken = 1'b0;
    repeat (4) begin
      tick(); cyc("frz2", 9'h030, 4'd2, 1'b1, rom_word(9'h030, 4'd0));
    end
    bus.clken = 1'b1;
    tick(); cyc("c3", 9'h030, 4'd3, 1'b1, rom_word(9'h030, 4'd1));

    // Asynchronous reset mid-sequence, then RESET sequence restarts
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("arst");
    tick();
    tick();
    rst_n = 1'b1;
    tick(); cyc("r1", 9'd256, 4'd1, 1'b0, '0);
    tick(); cyc("r2", 9'd256, 4'd2, 1'b1, rom_word(9'd256, 4'd0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
